io_channel_controller: RTL and testbench
========================================

IO_CHANNEL_CONTROLLER -- requirements
Module: io_channel_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of accumulator and device buses.
REQ-002 SHALL have parameter CHANNELS, default 4, number of attached devices (2..16).
REQ-003 SHALL have parameter CHSEL_W, default 2, channel-select width; SHALL be at least clog2(CHANNELS).
REQ-004 SHALL have parameter TIMEOUT, default 255, max cycles waited per handshake phase (1..65535).
REQ-005 clock  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  request to begin one transfer; sampled only in IDLE.
REQ-008 dir  in  1  0 = read from device, 1 = write to device; latched at accepted start.
REQ-009 chan  in  CHSEL_W  target channel; latched at accepted start.
REQ-010 wdata  in  WIDTH  write data; latched at accepted start.
REQ-011 busy  out  1  high from the cycle after an accepted start through the DONE cycle.
REQ-012 done  out  1  one-cycle pulse when a transfer ends, for any reason.
REQ-013 error  out  1  valid with done; 1 = timeout or invalid channel.
REQ-014 acc_write  out  1  one-cycle pulse with done on a successful read only.
REQ-015 rdata  out  WIDTH  captured read data; holds until the next capture.
REQ-016 dev_read  out  CHANNELS  one-hot read strobe.
REQ-017 dev_write  out  CHANNELS  one-hot write strobe.
REQ-018 dev_wdata  out  WIDTH  latched write data, driven to all channels.
REQ-019 dev_rdata  in  CHANNELS*WIDTH  channel k data in bits [k*WIDTH +: WIDTH].
REQ-020 dev_ack  in  CHANNELS  per-channel acknowledge.

Function
REQ-021 SHALL implement the states IDLE, REQ, RELEASE, DONE.
REQ-022 IDLE: start=1 with chan < CHANNELS -> latch dir/chan/wdata, load counter with TIMEOUT, go to REQ.
REQ-023 IDLE: start=1 with chan >= CHANNELS -> go to DONE with error=1; no strobe is asserted.
REQ-024 REQ: the strobe of the latched channel SHALL be high; dev_read for dir=0, dev_write for dir=1. All other strobe bits SHALL be 0.
REQ-025 REQ: dev_ack[chan]=1 -> for dir=0, capture dev_rdata slice into rdata. Reload the counter and go to RELEASE, dropping the strobe in that cycle.
REQ-026 REQ: ack low and counter=0 -> drop the strobe, go to DONE with error=1, leave rdata unchanged; otherwise decrement the counter.
REQ-027 RELEASE: dev_ack[chan]=0 -> go to DONE with error=0.
REQ-028 RELEASE: ack high and counter=0 -> go to DONE with error=1; for a read, rdata keeps the captured value but acc_write stays 0.
REQ-029 DONE: assert done for exactly one cycle, plus acc_write if dir=0 and error=0. Return to IDLE unconditionally.
REQ-030 Latency with immediate ack: start at cycle 0 -> strobe visible cycles 1..2, RELEASE cycle 3, done at cycle 4 if ack falls at cycle 3.
REQ-031 start while not in IDLE SHALL be ignored; the DONE cycle SHALL NOT accept start (earliest restart is the cycle after done).
REQ-032 dev_ack bits of non-selected channels SHALL be ignored in every state.
REQ-033 A timeout counter at TIMEOUT SHALL allow exactly TIMEOUT+1 sampled cycles before abort.
REQ-034 Strobe outputs SHALL be registered (glitch-free); dev_read and dev_write SHALL never both be nonzero.

Reset
REQ-035 reset low SHALL immediately force IDLE, regardless of clock.
REQ-036 On reset low: busy, done, error, acc_write, dev_read, dev_write = 0; rdata, dev_wdata = 0; counter = 0.
REQ-037 Reset mid-transfer SHALL drop strobes at once and SHALL produce no done pulse.

Verification
REQ-038 Read, chan=2, device acks one cycle after the strobe with dev_rdata[2]=16'hBEEF and drops ack after the strobe falls -> dev_read=4'b0100, then rdata=16'hBEEF, done=1, acc_write=1, error=0.
REQ-039 Write, chan=1, wdata=16'h1234 -> dev_write=4'b0010 and dev_wdata=16'h1234 until ack; done=1, acc_write=0, error=0.
REQ-040 Read, chan=3, ack never rises, TIMEOUT=4 -> strobe held 5 cycles, then done=1, error=1, acc_write=0, rdata unchanged.
REQ-041 chan=5 with CHANNELS=4 -> no strobe, done next cycle with error=1.
REQ-042 dev_ack[0]=1 held during a read of chan=1; start pulsed while busy -> chan 0 ack has no effect, second start dropped, exactly one done.
REQ-043 reset asserted low while in REQ -> strobes and busy 0 within the same cycle; no done; a new start after reset is accepted normally.

Source files
------------

// File: rtl/io_channel_controller.sv
// io_channel_controller: runs one handshake transfer at a time with one of
// CHANNELS attached devices. A transfer raises a registered one-hot strobe,
// waits for that channel's ack, drops the strobe, and waits for the ack to
// fall. Each phase is bounded by a TIMEOUT counter. Every transfer, including
// a rejected one, finishes with a single-cycle DONE state.
module io_channel_controller #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int CHSEL_W  = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      dir,
    input  logic [CHSEL_W-1:0]        chan,
    input  logic [WIDTH-1:0]          wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic                      acc_write,
    output logic [WIDTH-1:0]          rdata,
    output logic [CHANNELS-1:0]       dev_read,
    output logic [CHANNELS-1:0]       dev_write,
    output logic [WIDTH-1:0]          dev_wdata,
    input  logic [CHANNELS*WIDTH-1:0] dev_rdata,
    input  logic [CHANNELS-1:0]       dev_ack
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_RELEASE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // The counter is 16 bits wide because TIMEOUT can be as large as 65535.
    localparam logic [15:0] CNT_LOAD = 16'(TIMEOUT);

    state_t                state_q, state_d;
    logic                  dir_q, dir_d;
    logic [CHSEL_W-1:0]    chan_q, chan_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [CHANNELS-1:0]   rd_stb_q, rd_stb_d;
    logic [CHANNELS-1:0]   wr_stb_q, wr_stb_d;

    logic                  ack_sel;
    logic [WIDTH-1:0]      rd_sel;
    logic [CHANNELS-1:0]   start_oh;
    logic                  chan_ok;

    // Select the latched channel's ack and data. Acks from the other channels
    // never reach the state machine. Also decode the incoming channel to one-hot.
    always_comb begin
        ack_sel  = 1'b0;
        rd_sel   = '0;
        start_oh = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (chan_q == CHSEL_W'(k)) begin
                ack_sel = dev_ack[k];
                rd_sel  = dev_rdata[k*WIDTH +: WIDTH];
            end
            start_oh[k] = (chan == CHSEL_W'(k));
        end
        chan_ok = (32'(chan) < 32'(CHANNELS));
    end

    // Next-state logic. A strobe is only requested while the next state is
    // REQ, so the registered strobe drops in the same cycle the FSM leaves REQ.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        chan_d   = chan_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rd_stb_d = '0;
        wr_stb_d = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (chan_ok) begin
                        dir_d    = dir;
                        chan_d   = chan;
                        wdata_d  = wdata;
                        cnt_d    = CNT_LOAD;
                        err_d    = 1'b0;
                        state_d  = S_REQ;
                        rd_stb_d = dir ? '0 : start_oh;
                        wr_stb_d = dir ? start_oh : '0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_REQ: begin
                if (ack_sel) begin
                    if (!dir_q) rdata_d = rd_sel;
                    cnt_d   = CNT_LOAD;
                    state_d = S_RELEASE;
                end else if (cnt_q == 16'd0) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d    = cnt_q - 16'd1;
                    rd_stb_d = rd_stb_q;
                    wr_stb_d = wr_stb_q;
                end
            end
            S_RELEASE: begin
                if (!ack_sel) begin
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == 16'd0) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                // DONE never accepts start; the earliest restart is the next cycle.
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers. An asynchronous reset kills any transfer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            dir_q    <= 1'b0;
            chan_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rd_stb_q <= '0;
            wr_stb_q <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            chan_q   <= chan_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rd_stb_q <= rd_stb_d;
            wr_stb_q <= wr_stb_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign error     = done & err_q;
    assign acc_write = done & ~dir_q & ~err_q;
    assign rdata     = rdata_q;
    assign dev_read  = rd_stb_q;
    assign dev_write = wr_stb_q;
    assign dev_wdata = wdata_q;

endmodule

// File: tb/tb_io_channel_controller.sv
// Directed bench for io_channel_controller (WIDTH=16, CHANNELS=4, CHSEL_W=3,
// TIMEOUT=4). Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_io_channel_controller;

    localparam int W  = 16;
    localparam int CH = 4;
    localparam int CS = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          dir;
    logic [CS-1:0] chan;
    logic [W-1:0]  wdata;
    logic          busy, done, error, acc_write;
    logic [W-1:0]  rdata, dev_wdata;
    logic [CH-1:0] dev_read, dev_write, dev_ack;
    logic [CH*W-1:0] dev_rdata;

    int checks = 0;
    int errors = 0;

    io_channel_controller #(.WIDTH(W), .CHANNELS(CH), .CHSEL_W(CS), .TIMEOUT(4)) dut (
        .clock(clock), .reset(reset), .start(start), .dir(dir), .chan(chan),
        .wdata(wdata), .busy(busy), .done(done), .error(error),
        .acc_write(acc_write), .rdata(rdata), .dev_read(dev_read),
        .dev_write(dev_write), .dev_wdata(dev_wdata), .dev_rdata(dev_rdata),
        .dev_ack(dev_ack)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive start for one cycle, leaving the bench 1 ns after the accepting edge.
    task automatic kick(input logic d, input logic [CS-1:0] c, input logic [W-1:0] wd);
        start = 1'b1; dir = d; chan = c; wdata = wd;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, error, acc_write} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl got %b want 0000", {busy, done, error, acc_write});
        end
        checks++;
        if ({dev_read, dev_write} !== 8'h00 || rdata !== 16'h0 || dev_wdata !== 16'h0) begin
            errors++; $display("FAIL reset_data strobes %h rdata %h wdata %h want 0", {dev_read, dev_write}, rdata, dev_wdata);
        end
    endtask

    task automatic test_read();
        dev_rdata[2*W +: W] = 16'hBEEF;
        kick(1'b0, 3'd2, 16'h0);                // cycle 1: REQ
        checks++;
        if (dev_read !== 4'b0100 || dev_write !== 4'b0000 || busy !== 1'b1) begin
            errors++; $display("FAIL read_strobe rd %b wr %b busy %b want 0100 0000 1", dev_read, dev_write, busy);
        end
        step();                                  // cycle 2: still REQ
        checks++;
        if (dev_read !== 4'b0100) begin
            errors++; $display("FAIL read_strobe_hold got %b want 0100", dev_read);
        end
        dev_ack[2] = 1'b1;
        step();                                  // cycle 3: RELEASE
        checks++;
        if (dev_read !== 4'b0000 || rdata !== 16'hBEEF || done !== 1'b0) begin
            errors++; $display("FAIL read_release rd %b rdata %h done %b want 0000 beef 0", dev_read, rdata, done);
        end
        dev_ack[2] = 1'b0;
        step();                                  // cycle 4: DONE
        checks++;
        if ({done, error, acc_write} !== 3'b101 || rdata !== 16'hBEEF) begin
            errors++; $display("FAIL read_done d/e/a %b rdata %h want 101 beef", {done, error, acc_write}, rdata);
        end
        step();
        checks++;
        if ({busy, done, acc_write} !== 3'b000) begin
            errors++; $display("FAIL read_idle busy/done/acc %b want 000", {busy, done, acc_write});
        end
    endtask

    task automatic test_write();
        kick(1'b1, 3'd1, 16'h1234);
        checks++;
        if (dev_write !== 4'b0010 || dev_read !== 4'b0000 || dev_wdata !== 16'h1234) begin
            errors++; $display("FAIL write_strobe wr %b rd %b wdata %h want 0010 0000 1234", dev_write, dev_read, dev_wdata);
        end
        dev_ack[1] = 1'b1;
        step();                                  // RELEASE
        checks++;
        if (dev_write !== 4'b0000) begin
            errors++; $display("FAIL write_release wr %b want 0000", dev_write);
        end
        dev_ack[1] = 1'b0;
        step();                                  // DONE
        checks++;
        if ({done, error, acc_write} !== 3'b100 || rdata !== 16'hBEEF) begin
            errors++; $display("FAIL write_done d/e/a %b rdata %h want 100 beef", {done, error, acc_write}, rdata);
        end
        step();
    endtask

    task automatic test_req_timeout();
        int held = 0;
        dev_rdata[3*W +: W] = 16'h7777;
        kick(1'b0, 3'd3, 16'h0);
        for (int i = 0; i < 5; i++) begin
            if (dev_read === 4'b1000) held++;
            step();
        end
        checks++;
        if (held != 5 || dev_read !== 4'b0000) begin
            errors++; $display("FAIL req_timeout_hold cycles %0d rd %b want 5 0000", held, dev_read);
        end
        checks++;
        if ({done, error, acc_write} !== 3'b110 || rdata !== 16'hBEEF) begin
            errors++; $display("FAIL req_timeout_done d/e/a %b rdata %h want 110 beef", {done, error, acc_write}, rdata);
        end
        step();
    endtask

    task automatic test_release_timeout();
        dev_rdata[2*W +: W] = 16'h1111;
        kick(1'b0, 3'd2, 16'h0);
        dev_ack[2] = 1'b1;                       // held high forever
        step();                                  // RELEASE, counter 4
        for (int i = 0; i < 5; i++) step();      // counter 4..0 sampled
        checks++;
        if ({done, error, acc_write} !== 3'b110 || rdata !== 16'h1111) begin
            errors++; $display("FAIL release_timeout d/e/a %b rdata %h want 110 1111", {done, error, acc_write}, rdata);
        end
        dev_ack[2] = 1'b0;
        step();
    endtask

    task automatic test_bad_chan();
        kick(1'b0, 3'd5, 16'h0);
        checks++;
        if ({done, error, acc_write} !== 3'b110 || dev_read !== 4'b0000 || dev_write !== 4'b0000) begin
            errors++; $display("FAIL bad_chan d/e/a %b rd %b wr %b want 110 0000 0000", {done, error, acc_write}, dev_read, dev_write);
        end
        // Start held through the DONE cycle must not be taken there.
        start = 1'b1; dir = 1'b1; chan = 3'd0; wdata = 16'hCAFE;
        step();
        checks++;
        if (busy !== 1'b0 || dev_write !== 4'b0000) begin
            errors++; $display("FAIL done_no_start busy %b wr %b want 0 0000", busy, dev_write);
        end
        step();
        start = 1'b0;
        checks++;
        if (dev_write !== 4'b0001 || dev_wdata !== 16'hCAFE) begin
            errors++; $display("FAIL back_to_back wr %b wdata %h want 0001 cafe", dev_write, dev_wdata);
        end
        dev_ack[0] = 1'b1;
        step();
        dev_ack[0] = 1'b0;
        step();
        step();
    endtask

    task automatic test_ignore();
        int ndone = 0;
        dev_ack[0] = 1'b1;
        dev_rdata[1*W +: W] = 16'hA5A5;
        kick(1'b0, 3'd1, 16'h0);                 // REQ cycle 1
        start = 1'b1; dir = 1'b1; chan = 3'd2;   // spurious start while busy
        step();                                  // REQ cycle 2
        start = 1'b0;
        checks++;
        if (dev_read !== 4'b0010 || dev_write !== 4'b0000 || done !== 1'b0) begin
            errors++; $display("FAIL ignore_other_ack rd %b wr %b done %b want 0010 0000 0", dev_read, dev_write, done);
        end
        dev_ack[1] = 1'b1;
        step();                                  // RELEASE
        dev_ack[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) ndone++;
            step();
        end
        checks++;
        if (ndone != 1 || rdata !== 16'hA5A5 || dev_write !== 4'b0000) begin
            errors++; $display("FAIL ignore_single_done dones %0d rdata %h wr %b want 1 a5a5 0000", ndone, rdata, dev_write);
        end
        dev_ack[0] = 1'b0;
    endtask

    task automatic test_mid_reset();
        int ndone = 0;
        kick(1'b1, 3'd0, 16'h4321);
        checks++;
        if (dev_write !== 4'b0001) begin
            errors++; $display("FAIL mid_reset_pre wr %b want 0001", dev_write);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (dev_write !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || rdata !== 16'h0) begin
            errors++; $display("FAIL mid_reset_now wr %b busy %b done %b rdata %h want 0000 0 0 0", dev_write, busy, done, rdata);
        end
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) ndone++;
            step();
        end
        checks++;
        if (ndone != 0) begin
            errors++; $display("FAIL mid_reset_no_done dones %0d want 0", ndone);
        end
        dev_rdata[0 +: W] = 16'h0F0F;
        kick(1'b0, 3'd0, 16'h0);
        checks++;
        if (dev_read !== 4'b0001 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_reset_restart rd %b busy %b want 0001 1", dev_read, busy);
        end
        dev_ack[0] = 1'b1;
        step();
        dev_ack[0] = 1'b0;
        step();
        checks++;
        if ({done, error, acc_write} !== 3'b101 || rdata !== 16'h0F0F) begin
            errors++; $display("FAIL mid_reset_restart_done d/e/a %b rdata %h want 101 0f0f", {done, error, acc_write}, rdata);
        end
        step();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; dir = 1'b0; chan = '0; wdata = '0;
        dev_ack = '0; dev_rdata = '0;
        #12;
        test_reset();
        @(posedge clock); #1 reset = 1'b1;
        step();
        test_read();
        test_write();
        test_req_timeout();
        test_release_timeout();
        test_bad_chan();
        test_ignore();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
